// File: rtl/cnn_pkg.sv
// Shared types and width helpers for the CNN window-stream monitor.
package cnn_pkg;

    // Frame-tracking FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mon_state_t;

    // Default datapath geometry (3x3 window of 24-bit taps).
    localparam int unsigned DEF_DATA_W = 24;
    localparam int unsigned DEF_N_TAPS = 9;

    // Width needed to sum n_taps taps of data_w bits without overflow.
    function automatic int unsigned tap_sum_w(input int unsigned data_w,
                                              input int unsigned n_taps);
        return data_w + $clog2(n_taps);
    endfunction

    localparam int unsigned DEF_SUM_W = tap_sum_w(DEF_DATA_W, DEF_N_TAPS);

endpackage

// File: rtl/win_signature.sv
// Window signature: sums all taps of a window and folds the sum into a
// rotate-left-by-one / XOR register. Clear has priority over enable.
module win_signature
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned N_TAPS = DEF_N_TAPS,
    parameter int unsigned CHK_W  = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     en_i,
    input  logic                     clr_i,
    input  logic [N_TAPS*DATA_W-1:0] win_i,
    output logic [CHK_W-1:0]         sig_o,
    output logic [CHK_W-1:0]         sig_next_o
);

    localparam int unsigned SUM_W = tap_sum_w(DATA_W, N_TAPS);

    logic [SUM_W-1:0] tap_sum;
    logic [CHK_W-1:0] sig_q;
    logic [CHK_W-1:0] sig_d;
    logic [CHK_W-1:0] sig_step;

    // Adder over all taps at full precision.
    always_comb begin
        tap_sum = '0;
        for (int unsigned i = 0; i < N_TAPS; i++) begin
            tap_sum = tap_sum + SUM_W'(win_i[i*DATA_W +: DATA_W]);
        end
    end

    // One signature step: rotate left by one, XOR in the truncated/extended sum.
    always_comb begin
        sig_step = {sig_q[CHK_W-2:0], sig_q[CHK_W-1]} ^ CHK_W'(tap_sum);
        sig_d    = sig_q;
        if (clr_i) begin
            sig_d = '0;
        end else if (en_i) begin
            sig_d = sig_step;
        end
    end

    // Running signature register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o      = sig_q;
    assign sig_next_o = sig_step;

endmodule

// File: rtl/cnn_stream_monitor.sv
// Source pacing and output capture for the CNN window datapath: generates a
// stallable 1-of-EN_PERIOD input enable, tracks window position, signs each
// frame and flags protocol errors.
module cnn_stream_monitor
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned N_TAPS    = DEF_N_TAPS,
    parameter int unsigned EN_PERIOD = 16,
    parameter int unsigned OUT_W     = 478,
    parameter int unsigned OUT_H     = 270,
    parameter int unsigned CHK_W     = 32,
    parameter int unsigned TIMEOUT   = 4096
) (
    input  logic                       iClk,
    input  logic                       iRst,
    input  logic                       iBusy,
    input  logic                       iClr,
    input  logic                       iValid,
    input  logic [N_TAPS*DATA_W-1:0]   iWin,
    output logic                       oEn,
    output logic [$clog2(OUT_W)-1:0]   oX,
    output logic [$clog2(OUT_H)-1:0]   oY,
    output logic [CHK_W-1:0]           oChecksum,
    output logic                       oFrameDone,
    output logic [15:0]                oFrameCnt,
    output logic [1:0]                 oErr
);

    localparam int unsigned XW = $clog2(OUT_W);
    localparam int unsigned YW = $clog2(OUT_H);
    localparam int unsigned CW = $clog2(EN_PERIOD);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             cnt_wrap;

    mon_state_t       state_q;
    logic [XW-1:0]    x_q;
    logic [YW-1:0]    y_q;
    logic [TW-1:0]    tmo_q;
    logic [CHK_W-1:0] chk_q;
    logic             done_q;
    logic [15:0]      fcnt_q;
    logic [1:0]       err_q;

    logic             x_end;
    logic             y_end;
    logic             frame_fin;
    logic             tmo_hit;
    logic             sig_clr;
    logic [CHK_W-1:0] sig_cur;
    logic [CHK_W-1:0] sig_next;

    // Strobe counter next state: holds while downstream is busy.
    always_comb begin
        cnt_wrap = (cnt_q == CW'(EN_PERIOD - 1));
        cnt_d    = cnt_q;
        if (!iBusy) begin
            cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
        end
    end

    // Strobe counter register.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign oEn = cnt_wrap & ~iBusy;

    // Frame position and timeout decodes shared by the FSM and signature.
    always_comb begin
        x_end     = (x_q == XW'(OUT_W - 1));
        y_end     = (y_q == YW'(OUT_H - 1));
        frame_fin = iValid & x_end & y_end;
        tmo_hit   = (state_q == ST_RUN) & ~iValid & (tmo_q == TW'(TIMEOUT - 1));
        sig_clr   = frame_fin | tmo_hit;
    end

    // The final window's step is captured straight into the checksum on the
    // accepting edge, so the running signature can be cleared on that same
    // edge and a valid arriving during DONE starts the next frame from zero.
    win_signature #(
        .DATA_W (DATA_W),
        .N_TAPS (N_TAPS),
        .CHK_W  (CHK_W)
    ) u_sig (
        .clk_i      (iClk),
        .rst_ni     (iRst),
        .en_i       (iValid),
        .clr_i      (sig_clr),
        .win_i      (iWin),
        .sig_o      (sig_cur),
        .sig_next_o (sig_next)
    );

    // Frame FSM with registered position, checksum, frame count and errors.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            tmo_q   <= '0;
            chk_q   <= '0;
            done_q  <= 1'b0;
            fcnt_q  <= '0;
            err_q   <= '0;
        end else begin
            done_q <= frame_fin;
            err_q  <= (iClr ? 2'b00 : err_q) | {tmo_hit, iValid & iBusy};
            if (iClr) begin
                fcnt_q <= '0;
            end else if (frame_fin) begin
                fcnt_q <= fcnt_q + 1'b1;
            end

            if (iValid) begin
                tmo_q <= '0;
                if (x_end) begin
                    x_q <= '0;
                    if (y_end) begin
                        y_q     <= '0;
                        chk_q   <= sig_next;
                        state_q <= ST_DONE;
                    end else begin
                        y_q     <= y_q + 1'b1;
                        state_q <= ST_RUN;
                    end
                end else begin
                    x_q     <= x_q + 1'b1;
                    state_q <= ST_RUN;
                end
            end else begin
                unique case (state_q)
                    ST_RUN: begin
                        if (tmo_hit) begin
                            state_q <= ST_IDLE;
                            x_q     <= '0;
                            y_q     <= '0;
                            tmo_q   <= '0;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end
                    ST_DONE: state_q <= ST_IDLE;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign oX         = x_q;
    assign oY         = y_q;
    assign oChecksum  = chk_q;
    assign oFrameDone = done_q;
    assign oFrameCnt  = fcnt_q;
    assign oErr       = err_q;

endmodule
